omsp_tsc_ext: RTL and testbench
===============================

Name: omsp_tsc_ext

Overview:
Parametrised time-stamp counter peripheral on the openMSP430 peripheral bus. It is the successor of the fixed 64-bit free-running TSC. It adds:
- configurable counter width
- run/stop control
- power-of-two prescaler
- software clear
- explicit snapshot command
- compare register with sticky flag and interrupt

The live counter value is exported for other blocks, e.g. secure-module timing.

Parameters:
BASE_ADDR  15'h0100  byte base address; aligned to 2^DEC_WD
DEC_WD     5         address decode width (32-byte window)
CNT_WD     64        counter width; multiple of 16, legal 16..64

Ports:
mclk      in   1       main system clock
puc_rst   in   1       reset, synchronous, active-high
per_addr  in   14      peripheral word address
per_din   in   16      peripheral write data
per_en    in   1       peripheral enable
per_we    in   2       byte write enables ([0] low byte, [1] high byte)
per_dout  out  16      peripheral read data
tsc       out  CNT_WD  live counter value
tsc_irq   out  1       compare interrupt, level, = CMP_IFG & CMP_IE

Behaviour:
- One clock; reset is synchronous and active-high (mclk, puc_rst). All state updates on posedge mclk only.
- Reset values:
  - cnt = 0, snap = 0, cmp = all-ones.
  - CTL: EN = 1, IE = 0, IFG = 0, PRESC = 0.
  - Prescaler count = 0.
  - tsc_irq = 0.
- Register select: per_en & per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD].
- Write = sel & |per_we; read = sel & ~|per_we.
- per_dout is combinational in the access cycle. It is 0 when not reading or when the offset is unmapped.
- Register map (byte offsets):
  - 0x00 CTL, read/write:
    - bit0 EN
    - bit1 CMP_IE
    - bit2 CMP_IFG (write-1-to-clear)
    - bits7:4 PRESC
    - bit8 SNAP (write-1 action, reads 0)
    - bit9 CLR (write-1 action, reads 0)
    - other bits read 0
  - 0x02/0x04/0x06/0x08 SNAP0..3: read-only snapshot words, LSW first. Words at index >= CNT_WD/16 read 0. Writes are ignored.
  - 0x0A/0x0C/0x0E/0x10 CMP0..3: read/write compare words, byte-writable. Words at index >= CNT_WD/16 are absent (read 0, write ignored).
- Byte enables: per_we[0] updates bits 7:0 only; per_we[1] updates bits 15:8 only. SNAP/CLR are in the high byte and require per_we[1].
- Prescaler:
  - Internal 15-bit pre counter increments every cycle while EN = 1.
  - tick = EN & ((pre & M) == M), where M = 2^PRESC - 1.
  - PRESC = 0 gives a tick every cycle; PRESC = 15 maps to M = 0x7FFF.
  - pre is reset to 0 on CLR or on any write to the PRESC field.
- Counter:
  - On tick, cnt <= cnt + 1 modulo 2^CNT_WD; all-ones wraps to 0.
  - While EN = 0, cnt and pre hold.
  - CLR sets cnt <= 0 and overrides a tick in the same cycle.
- Snapshot:
  - Writing SNAP = 1 loads snap <= cnt (the pre-update value of that cycle).
  - SNAP together with CLR in one write captures the pre-clear value.
  - snap changes only on SNAP writes.
- Compare:
  - The set condition is an update that makes cnt transition to a value equal to the full-width CMP, either a tick or CLR with CMP = 0.
  - The set condition raises CMP_IFG on the same edge.
  - IFG is sticky; it clears only on a CTL write with bit2 = 1 and per_we[0].
  - Simultaneous set and clear leaves IFG = 1 (set wins).
  - Writing CMP equal to the current cnt does not set IFG.
- tsc_irq is registered-equivalent: it follows IFG and IE, both registers, with no additional delay.
- Reset mid-operation returns every register to its reset value on the next edge, regardless of concurrent bus writes.

Test Plan:
1. Reset, then idle 10 cycles, then SNAP write, then read SNAP0..3. Required: SNAP0 = 10 ± bus-cycle offset exactly per the bench model; SNAP1..3 = 0; tsc increments by 1 per cycle.
2. PRESC = 3 with CLR, then run 40 cycles. Required: cnt = 5. EN = 0 freezes cnt and tsc for 20 cycles; re-enable resumes from 5.
3. CNT_WD = 16, CMP0 = 0x0000, cnt preset via CLR then counted to 0xFFFF. Required: wrap to 0 sets IFG; tsc_irq = 1 only when IE = 1.
4. CMP = 0x20 with IE = 1. Required: IFG rises on the edge where cnt becomes 0x20. A W1C write coinciding with a second set event leaves IFG = 1; a later W1C alone clears it and tsc_irq drops.
5. Byte writes: per_we = 2'b01 to CMP0 with 0xABCD changes only the low byte. A CTL write with SNAP | CLR captures the old cnt in snap and cnt reads 0 after the edge. An unmapped offset 0x12 reads 0.
6. Assert puc_rst during an active SNAP/CLR write. Required: all registers equal reset values next cycle, per_dout = 0, tsc_irq = 0.

Source files
------------

// File: rtl/omsp_tsc_ext.sv
// Time-stamp counter peripheral for the openMSP430 peripheral bus: a prescaled,
// width-configurable counter with run/stop, clear, snapshot and a compare interrupt.
module omsp_tsc_ext #(
   parameter logic [14:0] BASE_ADDR = 15'h0100,
   parameter int          DEC_WD    = 5,
   parameter int          CNT_WD    = 64
) (
   input  logic              mclk,
   input  logic              puc_rst,
   input  logic [13:0]       per_addr,
   input  logic [15:0]       per_din,
   input  logic              per_en,
   input  logic [1:0]        per_we,
   output logic [15:0]       per_dout,
   output logic [CNT_WD-1:0] tsc,
   output logic              tsc_irq
);

   localparam logic [7:0] W_CTL   = 8'd0;
   localparam logic [7:0] W_SNAP0 = 8'd1;
   localparam logic [7:0] W_CMP0  = 8'd5;

   logic              reg_sel;
   logic              reg_wr;
   logic              reg_rd;
   logic [7:0]        reg_wrd;
   logic              ctl_lo_wr;
   logic              ctl_hi_wr;
   logic              snap_cmd;
   logic              clr_cmd;

   logic              en_q, en_d;
   logic              ie_q, ie_d;
   logic              ifg_q, ifg_d;
   logic [3:0]        presc_q, presc_d;
   logic [14:0]       pre_q, pre_d;
   logic [14:0]       presc_mask;
   logic              tick;
   logic [CNT_WD-1:0] cnt_q, cnt_d;
   logic [CNT_WD-1:0] cnt_inc;
   logic [CNT_WD-1:0] snap_q, snap_d;
   logic [CNT_WD-1:0] cmp_q, cmp_d;
   logic              cmp_hit;
   logic [63:0]       cmp_ext;
   logic [63:0]       snap_ext;
   logic              unused_din;

   // The register window is 2^DEC_WD bytes; reg_wrd is the word index inside it.
   assign reg_sel = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
   assign reg_wr  = reg_sel & (|per_we);
   assign reg_rd  = reg_sel & ~(|per_we);
   assign reg_wrd = 8'(per_addr[DEC_WD-2:0]);

   assign ctl_lo_wr = reg_wr & (reg_wrd == W_CTL) & per_we[0];
   assign ctl_hi_wr = reg_wr & (reg_wrd == W_CTL) & per_we[1];
   assign snap_cmd  = ctl_hi_wr & per_din[8];
   assign clr_cmd   = ctl_hi_wr & per_din[9];

   assign unused_din = ^{per_din[15:10], per_din[3]};

   assign presc_mask = 15'((16'd1 << presc_q) - 16'd1);
   assign tick       = en_q & ((pre_q & presc_mask) == presc_mask);
   assign cnt_inc    = cnt_q + CNT_WD'(1);

   // A clear overrides the tick, so it is the clear value that meets the compare.
   assign cmp_hit = clr_cmd ? (cmp_q == '0) : (tick & (cnt_inc == cmp_q));

   always_comb begin : ctl_next
      en_d    = en_q;
      ie_d    = ie_q;
      presc_d = presc_q;
      ifg_d   = ifg_q;
      if (ctl_lo_wr) begin
         en_d    = per_din[0];
         ie_d    = per_din[1];
         presc_d = per_din[7:4];
         if (per_din[2]) begin
            ifg_d = 1'b0;
         end
      end
      if (cmp_hit) begin
         ifg_d = 1'b1;
      end
   end

   always_comb begin : pre_next
      pre_d = pre_q;
      if (clr_cmd | ctl_lo_wr) begin
         pre_d = '0;
      end else if (en_q) begin
         pre_d = pre_q + 15'd1;
      end
   end

   always_comb begin : cnt_next
      cnt_d = cnt_q;
      if (clr_cmd) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = cnt_inc;
      end
   end

   always_comb begin : snap_next
      snap_d = snap_q;
      if (snap_cmd) begin
         snap_d = cnt_q;
      end
   end

   // Words beyond CNT_WD fall off in the truncation back to cmp_d.
   always_comb begin : cmp_next
      cmp_ext = 64'(cmp_q);
      for (int i = 0; i < 4; i++) begin
         if (reg_wr && (reg_wrd == (W_CMP0 + 8'(i)))) begin
            if (per_we[0]) begin
               cmp_ext[16*i +: 8] = per_din[7:0];
            end
            if (per_we[1]) begin
               cmp_ext[16*i+8 +: 8] = per_din[15:8];
            end
         end
      end
      cmp_d = cmp_ext[CNT_WD-1:0];
   end

   always_comb begin : read_mux
      snap_ext = 64'(snap_q);
      per_dout = 16'h0000;
      if (reg_rd) begin
         if (reg_wrd == W_CTL) begin
            per_dout = {8'h00, presc_q, 1'b0, ifg_q, ie_q, en_q};
         end
         for (int i = 0; i < 4; i++) begin
            if (reg_wrd == (W_SNAP0 + 8'(i))) begin
               per_dout = snap_ext[16*i +: 16];
            end
            if (reg_wrd == (W_CMP0 + 8'(i))) begin
               per_dout = cmp_ext[16*i +: 16];
            end
         end
      end
   end

   always_ff @(posedge mclk) begin
      if (puc_rst) begin
         en_q    <= 1'b1;
         ie_q    <= 1'b0;
         ifg_q   <= 1'b0;
         presc_q <= 4'h0;
         pre_q   <= '0;
         cnt_q   <= '0;
         snap_q  <= '0;
         cmp_q   <= '1;
      end else begin
         en_q    <= en_d;
         ie_q    <= ie_d;
         ifg_q   <= ifg_d;
         presc_q <= presc_d;
         pre_q   <= pre_d;
         cnt_q   <= cnt_d;
         snap_q  <= snap_d;
         cmp_q   <= cmp_d;
      end
   end

   assign tsc     = cnt_q;
   assign tsc_irq = ifg_q & ie_q;

endmodule

// File: tb/tb_omsp_tsc_ext.sv
// Bench for omsp_tsc_ext: a 64-bit and a 16-bit instance share one bus and are
// checked every cycle against a transaction-level model, plus literal expectations.
module tb_omsp_tsc_ext;

   localparam logic [14:0] BASE_ADDR = 15'h0100;

   logic        mclk = 1'b0;
   logic        puc_rst;
   logic [13:0] per_addr;
   logic [15:0] per_din;
   logic        per_en;
   logic [1:0]  per_we;
   logic [15:0] per_dout64, per_dout16;
   logic [63:0] tsc64;
   logic [15:0] tsc16;
   logic        irq64, irq16;
   logic        chk_en = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 mclk = ~mclk;

   omsp_tsc_ext #(.BASE_ADDR(BASE_ADDR), .DEC_WD(5), .CNT_WD(64)) dut (
      .mclk(mclk), .puc_rst(puc_rst), .per_addr(per_addr), .per_din(per_din),
      .per_en(per_en), .per_we(per_we), .per_dout(per_dout64), .tsc(tsc64),
      .tsc_irq(irq64)
   );

   omsp_tsc_ext #(.BASE_ADDR(BASE_ADDR), .DEC_WD(5), .CNT_WD(16)) dut16 (
      .mclk(mclk), .puc_rst(puc_rst), .per_addr(per_addr), .per_din(per_din),
      .per_en(per_en), .per_we(per_we), .per_dout(per_dout16), .tsc(tsc16),
      .tsc_irq(irq16)
   );

   // Index 0 models the 64-bit instance, index 1 the 16-bit one.
   typedef struct packed {
      logic [1:0][63:0] cnt;
      logic [1:0][63:0] snap;
      logic [1:0][63:0] cmp;
      logic [1:0]       ifg;
      logic             en;
      logic             ie;
      logic [3:0]       presc;
      logic [14:0]      pre;
   } mstate_t;

   mstate_t m;

   function automatic logic [63:0] wmask(int k);
      return (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_0000_FFFF;
   endfunction

   function automatic int bus_off();
      if (per_en && ((int'(per_addr) >> 4) == (int'(BASE_ADDR) >> 5))) begin
         return (int'(per_addr) % 16) * 2;
      end
      return -1;
   endfunction

   function automatic logic [15:0] model_read(int k);
      int off = bus_off();
      logic [15:0] r = 16'h0000;
      if (off < 0 || per_we != 2'b00) return 16'h0000;
      if (off == 0) begin
         r = 16'(m.en) | (16'(m.ie) << 1) | (16'(m.ifg[k]) << 2) | (16'(m.presc) << 4);
      end else if (off >= 2 && off <= 8) begin
         r = 16'(m.snap[k] >> (8 * (off - 2)));
      end else if (off >= 10 && off <= 16) begin
         r = 16'(m.cmp[k] >> (8 * (off - 10)));
      end
      return r;
   endfunction

   function automatic mstate_t model_reset();
      mstate_t n = '0;
      for (int k = 0; k < 2; k++) n.cmp[k] = wmask(k);
      n.en = 1'b1;
      return n;
   endfunction

   function automatic mstate_t model_next(mstate_t s);
      mstate_t     n   = s;
      int          off = bus_off();
      logic        wr  = (off >= 0) && (per_we != 2'b00);
      logic        lo  = wr && (off == 0) && per_we[0];
      logic        hi  = wr && (off == 0) && per_we[1];
      logic        clr = hi && per_din[9];
      logic        snp = hi && per_din[8];
      int unsigned p   = 32'd1 << s.presc;
      logic        tick = s.en && ((32'(s.pre) % p) == (p - 1));
      logic [63:0] nxt;
      logic [63:0] ncmp;
      int          sh;
      for (int k = 0; k < 2; k++) begin
         nxt = clr ? 64'd0 : (tick ? ((s.cnt[k] + 64'd1) & wmask(k)) : s.cnt[k]);
         n.cnt[k] = nxt;
         if (snp) n.snap[k] = s.cnt[k];
         if (lo && per_din[2]) n.ifg[k] = 1'b0;
         if ((clr || tick) && nxt == s.cmp[k]) n.ifg[k] = 1'b1;
         if (wr && off >= 10 && off <= 16) begin
            ncmp = s.cmp[k];
            sh   = 8 * (off - 10);
            if (per_we[0]) ncmp = (ncmp & ~(64'hFF << sh)) | (64'(per_din[7:0]) << sh);
            if (per_we[1]) ncmp = (ncmp & ~(64'hFF << (sh + 8))) | (64'(per_din[15:8]) << (sh + 8));
            n.cmp[k] = ncmp & wmask(k);
         end
      end
      if (lo) begin
         n.en    = per_din[0];
         n.ie    = per_din[1];
         n.presc = per_din[7:4];
      end
      if (clr || lo) n.pre = '0;
      else if (s.en) n.pre = s.pre + 15'd1;
      return n;
   endfunction

   always @(posedge mclk) begin
      m <= puc_rst ? model_reset() : model_next(m);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   always @(negedge mclk) begin
      if (chk_en) begin
         check("tsc64", tsc64, m.cnt[0]);
         check("tsc16", 64'(tsc16), m.cnt[1]);
         check("irq64", 64'(irq64), 64'(m.ie & m.ifg[0]));
         check("irq16", 64'(irq16), 64'(m.ie & m.ifg[1]));
         check("dout64", 64'(per_dout64), 64'(model_read(0)));
         check("dout16", 64'(per_dout16), 64'(model_read(1)));
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge mclk);
      #1;
   endtask

   task automatic bus_write(input int off, input logic [15:0] data, input logic [1:0] we);
      per_en   = 1'b1;
      per_we   = we;
      per_addr = 14'(BASE_ADDR >> 1) + 14'(off / 2);
      per_din  = data;
      @(posedge mclk);
      #1;
      per_en   = 1'b0;
      per_we   = 2'b00;
      per_addr = 14'h0000;
      per_din  = 16'h0000;
   endtask

   task automatic bus_read(input int off, output logic [15:0] d64, output logic [15:0] d16);
      per_en   = 1'b1;
      per_we   = 2'b00;
      per_addr = 14'(BASE_ADDR >> 1) + 14'(off / 2);
      @(negedge mclk);
      d64 = per_dout64;
      d16 = per_dout16;
      @(posedge mclk);
      #1;
      per_en   = 1'b0;
      per_addr = 14'h0000;
   endtask

   task automatic read_check(input string name, input int off, input logic [15:0] e64, input logic [15:0] e16);
      logic [15:0] d64, d16;
      bus_read(off, d64, d16);
      check({name, "_64"}, 64'(d64), 64'(e64));
      check({name, "_16"}, 64'(d16), 64'(e16));
   endtask

   task automatic tsc_check(input string name, input logic [63:0] e64, input logic [15:0] e16);
      check({name, "_64"}, tsc64, e64);
      check({name, "_16"}, 64'(tsc16), 64'(e16));
   endtask

   task automatic irq_check(input string name, input logic e64, input logic e16);
      check({name, "_64"}, 64'(irq64), 64'(e64));
      check({name, "_16"}, 64'(irq16), 64'(e16));
   endtask

   initial begin
      puc_rst  = 1'b1;
      per_en   = 1'b0;
      per_we   = 2'b00;
      per_addr = 14'h0000;
      per_din  = 16'h0000;
      repeat (2) @(posedge mclk);
      #1;
      puc_rst = 1'b0;
      chk_en  = 1'b1;
      tsc_check("rst_tsc", 64'd0, 16'd0);
      irq_check("rst_irq", 1'b0, 1'b0);

      // Free run, then snapshot
      idle(10);
      tsc_check("run10", 64'd10, 16'd10);
      bus_write(0, 16'h0100, 2'b10);
      tsc_check("run11", 64'd11, 16'd11);
      read_check("snap0", 2, 16'd10, 16'd10);
      read_check("snap1", 4, 16'd0, 16'd0);
      read_check("snap3", 8, 16'd0, 16'd0);

      // Prescaler 3 with clear, freeze and resume
      bus_write(0, 16'h0231, 2'b11);
      tsc_check("presc_clr", 64'd0, 16'd0);
      idle(40);
      tsc_check("presc40", 64'd5, 16'd5);
      read_check("ctl_presc", 0, 16'h0031, 16'h0031);
      bus_write(0, 16'h0030, 2'b01);
      idle(20);
      tsc_check("frozen", 64'd5, 16'd5);
      bus_write(0, 16'h0031, 2'b01);
      idle(7);
      tsc_check("resume7", 64'd5, 16'd5);
      idle(1);
      tsc_check("resume8", 64'd6, 16'd6);

      // 16-bit wrap onto CMP = 0
      bus_write(10, 16'h0000, 2'b11);
      read_check("cmp1_absent", 12, 16'hFFFF, 16'h0000);
      bus_write(0, 16'h0201, 2'b11);
      read_check("ctl_clr_hit", 0, 16'h0001, 16'h0005);
      bus_write(0, 16'h0005, 2'b01);
      idle(65533);
      tsc_check("pre_wrap", 64'h0000_0000_0000_FFFF, 16'hFFFF);
      idle(1);
      tsc_check("wrap", 64'h0000_0000_0001_0000, 16'h0000);
      irq_check("wrap_irq_ie0", 1'b0, 1'b0);
      read_check("ctl_wrap", 0, 16'h0001, 16'h0005);
      bus_write(0, 16'h0003, 2'b01);
      irq_check("wrap_irq_ie1", 1'b0, 1'b1);

      // CMP = 0x20, W1C racing a set, then W1C alone
      bus_write(10, 16'h0020, 2'b11);
      bus_write(12, 16'h0000, 2'b11);
      bus_write(14, 16'h0000, 2'b11);
      bus_write(16, 16'h0000, 2'b11);
      bus_write(0, 16'h0207, 2'b11);
      irq_check("cmp_armed", 1'b0, 1'b0);
      idle(31);
      tsc_check("cmp_1f", 64'h1F, 16'h1F);
      irq_check("cmp_before", 1'b0, 1'b0);
      idle(1);
      irq_check("cmp_hit", 1'b1, 1'b1);
      bus_write(0, 16'h0203, 2'b11);
      irq_check("cmp_sticky", 1'b1, 1'b1);
      idle(31);
      bus_write(0, 16'h0007, 2'b01);
      irq_check("set_wins", 1'b1, 1'b1);
      bus_write(0, 16'h0007, 2'b01);
      irq_check("w1c_clear", 1'b0, 1'b0);

      // Byte write, SNAP|CLR, unmapped offset, read-only snapshot
      bus_write(10, 16'hABCD, 2'b01);
      read_check("cmp0_byte", 10, 16'h00CD, 16'h00CD);
      bus_write(0, 16'h0303, 2'b11);
      tsc_check("snapclr_tsc", 64'd0, 16'd0);
      read_check("snapclr_snap", 2, 16'h0023, 16'h0023);
      read_check("unmapped", 18, 16'h0000, 16'h0000);
      bus_write(2, 16'h5555, 2'b11);
      read_check("snap_ro", 2, 16'h0023, 16'h0023);

      // PRESC = 15 gives no tick within a short run
      bus_write(0, 16'h02F3, 2'b11);
      idle(100);
      tsc_check("presc15", 64'd0, 16'd0);
      read_check("ctl_p15", 0, 16'h00F3, 16'h00F3);

      // Reset during an active SNAP|CLR write with the interrupt pending
      bus_write(10, 16'h0000, 2'b11);
      bus_write(0, 16'h0203, 2'b11);
      irq_check("pre_rst_irq", 1'b1, 1'b1);
      per_en   = 1'b1;
      per_we   = 2'b11;
      per_addr = 14'(BASE_ADDR >> 1);
      per_din  = 16'h0303;
      puc_rst  = 1'b1;
      @(posedge mclk);
      #1;
      puc_rst  = 1'b0;
      per_en   = 1'b0;
      per_we   = 2'b00;
      per_addr = 14'h0000;
      per_din  = 16'h0000;
      tsc_check("rst2_tsc", 64'd0, 16'd0);
      irq_check("rst2_irq", 1'b0, 1'b0);
      check("rst2_dout64", 64'(per_dout64), 64'd0);
      check("rst2_dout16", 64'(per_dout16), 64'd0);
      read_check("rst2_ctl", 0, 16'h0001, 16'h0001);
      read_check("rst2_cmp0", 10, 16'hFFFF, 16'hFFFF);
      read_check("rst2_cmp3", 16, 16'hFFFF, 16'h0000);
      read_check("rst2_snap0", 2, 16'h0000, 16'h0000);

      idle(2);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
